vram_scan_arbiter: RTL and testbench
====================================

// Module: vram_scan_arbiter
// PURPOSE
//  Shares one single-port synchronous video RAM (128x96 pixels) between the VGA display
//  scan and a pixel-writer client. Display reads own the RAM whenever the H and V timing
//  FSMs report the visible area. Writer requests go into a small FIFO and drain only
//  during blanking. Sits between HSYNC/VSYNC timing FSMs, the frame-buffer BRAM and RGB out.
// PARAMETERS
//  ADDR_W      14  RAM address width; address = {VPIXEL, HPIXEL}
//  DATA_W       3  pixel width (R,G,B)
//  FIFO_DEPTH   4  write FIFO entries (power of 2, >=2)
//  V_MAX       95  last valid row; writes with addr[13:7] > V_MAX are discarded
// PORTS
//  clk           in   1                        system clock, all logic on rising edge
//  reset         in   1                        asynchronous, active-low (0 = reset)
//  offDisplay_H  in   1                        1 = horizontal blanking (from HSYNC FSM)
//  offDisplay_V  in   1                        1 = vertical blanking (from VSYNC FSM)
//  HPIXEL        in   7                        current column 0..127
//  VPIXEL        in   7                        current row 0..95
//  wr_valid      in   1                        writer request valid
//  wr_ready      out  1                        FIFO can accept (not full)
//  wr_addr       in   ADDR_W                   writer pixel address
//  wr_data       in   DATA_W                   writer pixel value
//  mem_en        out  1                        RAM access enable
//  mem_we        out  1                        RAM write enable (only with mem_en)
//  mem_addr      out  ADDR_W                   RAM address
//  mem_wdata     out  DATA_W                   RAM write data
//  mem_rdata     in   DATA_W                   RAM read data, valid 1 cycle after read
//  pixel_rgb     out  DATA_W                   registered pixel to DAC; 0 when not valid
//  pixel_valid   out  1                        pixel_rgb carries display data
//  fifo_level    out  $clog2(FIFO_DEPTH+1)     current FIFO occupancy
//  wr_drop       out  1                        sticky: an out-of-range write was discarded
// BEHAVIOUR
//  - Reset (async, reset=0): state S_BLANK, FIFO flushed, every output 0 except
//    wr_ready=1. wr_ready=1 holds while reset is low and on the first edge after release.
//  - Definition: active = ~offDisplay_H & ~offDisplay_V, sampled at each rising edge.
//  - FSM (registered): S_BLANK, S_WRITE, S_DISP.
//      any state -> S_DISP when active.
//      S_DISP -> S_BLANK when !active.
//      S_BLANK -> S_WRITE when !active & level>0.
//      S_WRITE stays while !active & level>1 after this pop; otherwise -> S_BLANK.
//  - RAM port (registered, 1 issue per cycle, display has absolute priority):
//      active: mem_en=1, mem_we=0, mem_addr={VPIXEL,HPIXEL}.
//      else if level>0: pop the FIFO head.
//        In range: mem_en=1, mem_we=1, mem_addr/mem_wdata = entry.
//        Out of range: mem_en=0, wr_drop<=1.
//      else: mem_en=0, mem_we=0; addr and data hold their last values.
//  - A write is never issued in a cycle sampled active. A pending head is kept, not
//    popped, and goes out at the next blanking cycle. Writes leave in FIFO order.
//  - Read pipeline: read issued at edge N; mem_rdata is captured into pixel_rgb at N+2
//    with pixel_valid=1. Otherwise pixel_rgb=0 and pixel_valid=0 at the same offset.
//  - FIFO
//      Push on wr_valid & wr_ready. wr_ready = (level < FIFO_DEPTH), from registered level.
//      When full, no push in the same cycle as a pop, even though a slot frees.
//      No bypass: an entry pushed at edge N is popped no earlier than edge N+1.
//      Simultaneous push and pop leaves level unchanged.
//      Pointers wrap modulo FIFO_DEPTH.
//  - wr_drop clears only on reset. Reset mid-drain aborts immediately; FIFO contents are lost.
// TESTING
//  1. Hold reset=0 with wr_valid=1 -> mem_en=0, pixel_valid=0, fifo_level=0, wr_ready=1,
//     no push; after release, first push happens on the next edge.
//  2. active with H=5, V=3 -> mem_en=1, we=0, mem_addr=0x185 one edge later;
//     mem_rdata=3'b101 -> pixel_rgb=3'b101, valid, 2 edges after the sample.
//  3. During display push 4 writes (0x0000..0x0003) -> fifo_level=4, wr_ready=0, no mem_we.
//     Then blank -> 4 consecutive mem_we cycles in order, wr_ready=1 after the first pop.
//  4. Blanking with 2 queued writes, active rises after the first write -> second write
//     held (level=1). It is issued on the first cycle of the next blanking interval.
//  5. Queue wr_addr=0x3000 (row 96) in blanking -> popped, mem_en=0 that cycle,
//     wr_drop=1 and sticky until reset.
//  6. Assert reset while level=3 mid-drain -> mem_en=0 and fifo_level=0 asynchronously;
//     no write after release.

Source files
------------

// File: rtl/vram_scan_arbiter.sv
// vram_scan_arbiter: shares one single-port synchronous video RAM between the
// display scan (absolute priority in the visible area) and a pixel-writer
// client whose requests are queued and drained only during blanking.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   offDisplay_H/V             blanking flags from the HSYNC/VSYNC timing FSMs
//   HPIXEL, VPIXEL             current scan column / row
//   wr_valid/ready/addr/data   writer request interface (FIFO push side)
//   mem_en/we/addr/wdata/rdata single-port RAM interface (1-cycle read latency)
//   pixel_rgb, pixel_valid     registered pixel to the DAC
//   fifo_level                 write FIFO occupancy
//   wr_drop                    sticky flag: an out-of-range write was discarded
module vram_scan_arbiter #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DATA_W     = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned V_MAX      = 95
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               offDisplay_H,
  input  logic                               offDisplay_V,
  input  logic [6:0]                         HPIXEL,
  input  logic [6:0]                         VPIXEL,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [ADDR_W-1:0]                  wr_addr,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic                               mem_en,
  output logic                               mem_we,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic [DATA_W-1:0]                  mem_wdata,
  input  logic [DATA_W-1:0]                  mem_rdata,
  output logic [DATA_W-1:0]                  pixel_rgb,
  output logic                               pixel_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               wr_drop
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned ROW_W = ADDR_W - 7;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic [1:0] {S_BLANK, S_WRITE, S_DISP} state_t;

  state_t             state;
  wr_req_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               rd_s0;
  logic               rd_s1;

  logic               active_c;
  logic               push_c;
  logic               pop_c;
  logic               head_ok_c;
  wr_req_t            head_c;
  logic [LVL_W-1:0]   level_nxt_c;

  // Arbitration decode: display wins, writes drain only when not active.
  always_comb begin
    active_c    = ~offDisplay_H & ~offDisplay_V;
    push_c      = wr_valid & wr_ready;
    pop_c       = ~active_c & (fifo_level != '0);
    head_c      = fifo_mem[rd_ptr];
    head_ok_c   = head_c.addr[ADDR_W-1:7] <= ROW_W'(V_MAX);
    level_nxt_c = fifo_level + LVL_W'(push_c) - LVL_W'(pop_c);
  end

  // FIFO storage; no reset needed since level gates every read.
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr] <= '{addr: wr_addr, data: wr_data};
  end

  // Control state, FIFO bookkeeping, RAM port and pixel pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_BLANK;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      wr_ready    <= 1'b1;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rd_s0       <= 1'b0;
      rd_s1       <= 1'b0;
      pixel_rgb   <= '0;
      pixel_valid <= 1'b0;
      wr_drop     <= 1'b0;
    end else begin
      if (active_c) begin
        state <= S_DISP;
      end else begin
        case (state)
          S_DISP:  state <= S_BLANK;
          S_BLANK: state <= (fifo_level != '0) ? S_WRITE : S_BLANK;
          S_WRITE: state <= (level_nxt_c != '0) ? S_WRITE : S_BLANK;
          default: state <= S_BLANK;
        endcase
      end

      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level <= level_nxt_c;
      wr_ready   <= level_nxt_c < LVL_W'(FIFO_DEPTH);

      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if (active_c) begin
        mem_en   <= 1'b1;
        mem_addr <= ADDR_W'({VPIXEL, HPIXEL});
      end else if (pop_c) begin
        if (head_ok_c) begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= head_c.addr;
          mem_wdata <= head_c.data;
        end else begin
          wr_drop <= 1'b1;
        end
      end

      // Read issued at edge N returns data captured here at N+2.
      rd_s0       <= active_c;
      rd_s1       <= rd_s0;
      pixel_valid <= rd_s1;
      pixel_rgb   <= rd_s1 ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Directed bench for vram_scan_arbiter with a behavioural 1-cycle-latency RAM.
module tb_vram_scan_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        offDisplay_H, offDisplay_V;
  logic [6:0]  HPIXEL, VPIXEL;
  logic        wr_valid, wr_ready;
  logic [13:0] wr_addr;
  logic [2:0]  wr_data;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [2:0]  mem_wdata;
  logic [2:0]  mem_rdata = 3'd0;
  logic [2:0]  pixel_rgb;
  logic        pixel_valid;
  logic [2:0]  fifo_level;
  logic        wr_drop;

  int errors = 0;
  int checks = 0;

  vram_scan_arbiter dut (
    .clk(clk), .reset(reset),
    .offDisplay_H(offDisplay_H), .offDisplay_V(offDisplay_V),
    .HPIXEL(HPIXEL), .VPIXEL(VPIXEL),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pixel_rgb(pixel_rgb), .pixel_valid(pixel_valid),
    .fifo_level(fifo_level), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  // RAM read model: address 0x185 holds 5, everything else returns addr[2:0].
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= (mem_addr == 14'h185) ? 3'd5 : mem_addr[2:0];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; offDisplay_H = 1'b1; offDisplay_V = 1'b1; HPIXEL = 7'd0; VPIXEL = 7'd0;
    wr_valid = 1'b1; wr_addr = 14'h0010; wr_data = 3'd1;
    repeat (3) tick();
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got %0b want 0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %0b want 0", mem_we); end
    checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL rst_pixel_valid got %0b want 0", pixel_valid); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d want 0", fifo_level); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready got %0b want 1", wr_ready); end
    reset = 1'b1;
    tick();
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL first_push_level got %0d want 1", fifo_level); end
    wr_valid = 1'b0;
    tick();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 14'h0010 || mem_wdata !== 3'd1)
      begin errors++; $display("FAIL first_write got we=%0b addr=%h data=%0d want we=1 addr=0010 data=1", mem_we, mem_addr, mem_wdata); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL first_write_level got %0d want 0", fifo_level); end
  endtask

  task automatic test_display_read;
    offDisplay_H = 1'b0; offDisplay_V = 1'b0; HPIXEL = 7'd5; VPIXEL = 7'd3;
    tick();
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 14'h185)
      begin errors++; $display("FAIL read_issue got en=%0b we=%0b addr=%h want en=1 we=0 addr=0185", mem_en, mem_we, mem_addr); end
    offDisplay_H = 1'b1;
    tick();
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL blank_no_read got %0b want 0", mem_en); end
    checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL pixel_early got %0b want 0", pixel_valid); end
    tick();
    checks++; if (pixel_valid !== 1'b1 || pixel_rgb !== 3'b101)
      begin errors++; $display("FAIL pixel_n2 got valid=%0b rgb=%b want valid=1 rgb=101", pixel_valid, pixel_rgb); end
    tick();
    checks++; if (pixel_valid !== 1'b0 || pixel_rgb !== 3'b000)
      begin errors++; $display("FAIL pixel_n3 got valid=%0b rgb=%b want valid=0 rgb=000", pixel_valid, pixel_rgb); end
  endtask

  task automatic test_fifo_fill;
    offDisplay_H = 1'b0; offDisplay_V = 1'b0; HPIXEL = 7'd0; VPIXEL = 7'd0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 14'(i); wr_data = 3'(i + 1);
      tick();
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fill_no_we[%0d] got %0b want 0", i, mem_we); end
    end
    wr_addr = 14'h0007; wr_data = 3'd7;
    tick();
    wr_valid = 1'b0;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_level got %0d want 4", fifo_level); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready got %0b want 0", wr_ready); end
    offDisplay_V = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (mem_we !== 1'b1 || mem_addr !== 14'(i) || mem_wdata !== 3'(i + 1))
        begin errors++; $display("FAIL drain[%0d] got we=%0b addr=%h data=%0d want we=1 addr=%h data=%0d", i, mem_we, mem_addr, mem_wdata, 14'(i), i + 1); end
      checks++; if (fifo_level !== 3'(3 - i)) begin errors++; $display("FAIL drain_level[%0d] got %0d want %0d", i, fifo_level, 3 - i); end
      if (i == 0) begin
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop got %0b want 1", wr_ready); end
      end
    end
    tick();
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0)
      begin errors++; $display("FAIL drain_done got en=%0b we=%0b want 0 0", mem_en, mem_we); end
  endtask

  task automatic test_held_write;
    offDisplay_H = 1'b0; offDisplay_V = 1'b0; HPIXEL = 7'd1; VPIXEL = 7'd1;
    wr_valid = 1'b1; wr_addr = 14'h0020; wr_data = 3'd6;
    tick();
    wr_addr = 14'h0021; wr_data = 3'd7;
    tick();
    wr_valid = 1'b0;
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL held_level2 got %0d want 2", fifo_level); end
    offDisplay_H = 1'b1;
    tick();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 14'h0020 || mem_wdata !== 3'd6)
      begin errors++; $display("FAIL held_first got we=%0b addr=%h data=%0d want we=1 addr=0020 data=6", mem_we, mem_addr, mem_wdata); end
    offDisplay_H = 1'b0;
    tick();
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 14'h0081)
      begin errors++; $display("FAIL held_read got en=%0b we=%0b addr=%h want en=1 we=0 addr=0081", mem_en, mem_we, mem_addr); end
    tick();
    checks++; if (fifo_level !== 3'd1 || mem_we !== 1'b0)
      begin errors++; $display("FAIL held_pending got level=%0d we=%0b want level=1 we=0", fifo_level, mem_we); end
    offDisplay_H = 1'b1;
    tick();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 14'h0021 || mem_wdata !== 3'd7 || fifo_level !== 3'd0)
      begin errors++; $display("FAIL held_second got we=%0b addr=%h data=%0d level=%0d want we=1 addr=0021 data=7 level=0", mem_we, mem_addr, mem_wdata, fifo_level); end
  endtask

  task automatic test_drop;
    offDisplay_H = 1'b1; offDisplay_V = 1'b1;
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL drop_initial got %0b want 0", wr_drop); end
    wr_valid = 1'b1; wr_addr = 14'h3000; wr_data = 3'd5;
    tick();
    wr_valid = 1'b0;
    tick();
    checks++; if (mem_en !== 1'b0 || wr_drop !== 1'b1 || fifo_level !== 3'd0)
      begin errors++; $display("FAIL drop_row96 got en=%0b drop=%0b level=%0d want en=0 drop=1 level=0", mem_en, wr_drop, fifo_level); end
    wr_valid = 1'b1; wr_addr = 14'h2FFF; wr_data = 3'd2;
    tick();
    wr_valid = 1'b0;
    tick();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 14'h2FFF || mem_wdata !== 3'd2)
      begin errors++; $display("FAIL row95_write got we=%0b addr=%h data=%0d want we=1 addr=2fff data=2", mem_we, mem_addr, mem_wdata); end
    repeat (3) tick();
    checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL drop_sticky got %0b want 1", wr_drop); end
  endtask

  task automatic test_reset_mid_drain;
    offDisplay_H = 1'b0; offDisplay_V = 1'b0; HPIXEL = 7'd2; VPIXEL = 7'd2;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 14'(14'h40 + i); wr_data = 3'(i);
      tick();
    end
    wr_valid = 1'b0;
    offDisplay_H = 1'b1;
    tick();
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL mid_drain_level got %0d want 3", fifo_level); end
    #2 reset = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL async_rst_mem got en=%0b we=%0b want 0 0", mem_en, mem_we); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL async_rst_level got %0d want 0", fifo_level); end
    checks++; if (wr_ready !== 1'b1 || wr_drop !== 1'b0)
      begin errors++; $display("FAIL async_rst_flags got ready=%0b drop=%0b want 1 0", wr_ready, wr_drop); end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL post_rst_idle[%0d] got en=%0b want 0", i, mem_en); end
    end
  endtask

  initial begin
    test_reset();
    test_display_read();
    test_fifo_fill();
    test_held_write();
    test_drop();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
